max_pool_stream: RTL and testbench
==================================

MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 69: signed width of conv result samples.
REQ-002 SHALL have parameter IN_DIM, default 24: input feature-map side; must be even; output side is IN_DIM/2.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port enable, input, 1: run permission; low pauses the stage.
REQ-006 SHALL have port in_valid, input, 1: in_data carries a conv sample.
REQ-007 SHALL have port in_ready, output, 1: the stage accepts a sample this cycle.
REQ-008 SHALL have port in_data, input, DATA_W: signed conv sample, raster order, row-major.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a pooled value.
REQ-010 SHALL have port out_ready, input, 1: the consumer takes out_data this cycle.
REQ-011 SHALL have port out_data, output, DATA_W: signed 2x2 max.
REQ-012 SHALL have ports out_row and out_col, output, $clog2(IN_DIM/2) each: pooled coordinates of out_data.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse when the last pooled value of a frame is accepted.

Function
REQ-014 SHALL accept a sample only on in_valid && in_ready, where in_ready = enable && !(out_valid && !out_ready) && state != FLUSH.
REQ-015 SHALL track input position with row/col counters (0..IN_DIM-1); col wraps to 0 and row increments at col IN_DIM-1; row wraps to 0 after row IN_DIM-1.
REQ-016 SHALL hold one pending value: the input sample at an even col is latched; at the next odd col the signed max of the pair is formed.
REQ-017 SHALL, on even rows, write the pair max into line-buffer entry col/2 (IN_DIM/2 entries, DATA_W each).
REQ-018 SHALL, on odd rows, load out_data with the signed max of the pair max and line-buffer entry col/2, set out_valid on the next cycle (latency 1 from the accepting edge), and set out_row=row/2, out_col=col/2.
REQ-019 SHALL keep out_valid and out_data stable until out_ready; clear out_valid on acceptance unless a new value loads in the same cycle.
REQ-020 SHALL use FSM states IDLE (enable low, nothing pending), RUN (accepting), FLUSH (final output of frame awaiting acceptance); IDLE->RUN on enable; RUN->FLUSH on accepting sample (IN_DIM-1, IN_DIM-1); FLUSH->RUN (enable high) or IDLE (enable low) when out_ready with out_valid.
REQ-021 SHALL pulse frame_done exactly in the cycle after the FLUSH output is accepted.
REQ-022 SHALL, on enable low mid-frame, freeze counters, line buffer, and pending value; a pending out_valid may still drain.
REQ-023 SHALL compare as two's-complement; equal operands yield that value.

Reset
REQ-024 SHALL, on rst, set state IDLE, counters 0, out_valid 0, out_data 0, out_row/out_col 0, frame_done 0, in_ready 0; line-buffer contents need not reset.
REQ-025 SHALL treat rst mid-frame as frame abort; the next accepted sample is (0,0).

Configuration
REQ-026 SHALL, when macro POOL_RELU_EN is defined, output max(pooled, 0) (negative clamps to 0); without it, output the raw signed max.

Structure
REQ-027 SHALL take DATA_W, CONV_DIM=24, POOL_DIM=12 and the FSM state enum from shared package simplecnn_pkg.
REQ-028 SHALL instantiate sub-module pool_max2 (combinational signed two-input max) for pair and vertical compares.

Verification
REQ-029 Ramp frame in_data=r*24+c, out_ready=1 -> 144 outputs, out(i,j)=(2i+1)*24+2j+1, frame_done once after out(11,11).
REQ-030 All samples -5 -> outputs -5 without POOL_RELU_EN, 0 with it.
REQ-031 out_ready low for 10 cycles at first output -> in_ready low, out_data held, no loss, ramp values still correct.
REQ-032 enable low for 5 cycles mid row 7 -> counters frozen, resumed outputs match ramp.
REQ-033 rst at sample (13,5), then fresh ramp frame -> outputs start at (0,0) with value 25, 144 outputs.
REQ-034 Two back-to-back frames, enable high -> 288 outputs, two frame_done pulses, no gap beyond FLUSH.

Source files
------------

// File: rtl/simplecnn_pkg.sv
// rtl/simplecnn_pkg.sv - shared CNN sizes and the pooling-stage FSM state type
package simplecnn_pkg;

  localparam int DATA_W   = 69;
  localparam int CONV_DIM = 24;
  localparam int POOL_DIM = CONV_DIM / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pool_state_e;

endpackage

// File: rtl/pool_max2.sv
// rtl/pool_max2.sv - combinational two's-complement two-input max
module pool_max2 #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] max_o
);

  assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/max_pool_stream.sv
// rtl/max_pool_stream.sv - streaming 2x2 signed max-pool over a raster-order conv map
// Define POOL_RELU_EN to clamp negative pooled values to zero.
module max_pool_stream #(
  parameter int DATA_W = simplecnn_pkg::DATA_W,
  parameter int IN_DIM = simplecnn_pkg::CONV_DIM
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_W-1:0]       in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_W-1:0]       out_data,
  output logic [$clog2(IN_DIM/2)-1:0]    out_row,
  output logic [$clog2(IN_DIM/2)-1:0]    out_col,
  output logic                           frame_done
);

  import simplecnn_pkg::*;

  localparam int PD = IN_DIM / 2;
  localparam int CW = $clog2(IN_DIM);
  localparam int PW = $clog2(PD);

  pool_state_e state_q, state_d;

  logic [CW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic signed [DATA_W-1:0] pend_q;
  logic signed [DATA_W-1:0] lb_q [PD];
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic [PW-1:0]            out_row_q, out_col_q;
  logic                     frame_done_q, frame_done_d;

  logic                     accept, last_sample, emit;
  logic [PW-1:0]            lb_idx;
  logic signed [DATA_W-1:0] pair_max, vert_max, pooled;

  assign in_ready    = !rst && enable && !(out_valid_q && !out_ready) && (state_q != FLUSH);
  assign accept      = in_valid && in_ready;
  assign last_sample = (row_q == CW'(IN_DIM - 1)) && (col_q == CW'(IN_DIM - 1));
  assign lb_idx      = col_q[CW-1:1];
  assign emit        = accept && row_q[0] && col_q[0];

  pool_max2 #(.W(DATA_W)) u_pair_max (
    .a_i   (pend_q),
    .b_i   (in_data),
    .max_o (pair_max)
  );

  pool_max2 #(.W(DATA_W)) u_vert_max (
    .a_i   (pair_max),
    .b_i   (lb_q[lb_idx]),
    .max_o (vert_max)
  );

`ifdef POOL_RELU_EN
  assign pooled = vert_max[DATA_W-1] ? '0 : vert_max;
`else
  assign pooled = vert_max;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && last_sample) state_d = FLUSH;
               else if (enable)           state_d = RUN;
      RUN:     if (accept && last_sample) state_d = FLUSH;
               else if (!enable)          state_d = IDLE;
      FLUSH:   if (out_valid_q && out_ready) state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frame_done_d = (state_q == FLUSH) && out_valid_q && out_ready;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (col_q == CW'(IN_DIM - 1)) begin
        col_d = '0;
        row_d = (row_q == CW'(IN_DIM - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      pend_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      if (accept && !col_q[0]) pend_q <= in_data;
      // A new pooled value may load in the same cycle the previous one is taken.
      if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pooled;
        out_row_q   <= row_q[CW-1:1];
        out_col_q   <= col_q[CW-1:1];
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Even rows park their horizontal pair max until the odd row below arrives.
  always_ff @(posedge clk) begin
    if (accept && !row_q[0] && col_q[0]) lb_q[lb_idx] <= pair_max;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// tb/tb_max_pool_stream.sv - randomized self-checking bench with a frame-level 2x2 max model
module tb_max_pool_stream;

  localparam int DW      = 69;
  localparam int N       = 24;
  localparam int P       = N / 2;
  localparam int PW      = $clog2(P);
  localparam int MAX_CYC = 4000;

  typedef struct {
    logic signed [DW-1:0] v;
    int                   r;
    int                   c;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst, enable, in_valid, in_ready;
  logic                 out_valid, out_ready, frame_done;
  logic signed [DW-1:0] in_data, out_data;
  logic [PW-1:0]        out_row, out_col;

  logic signed [DW-1:0] frame [N][N];
  exp_t                 exp_q[$];
  int                   n_cmp = 0;
  int                   n_bad = 0;
  int                   in_r = 0, in_c = 0, accepted = 0;
  int                   n_out = 0, n_fd = 0;
  int                   gap_pct = 0, stall_pct = 0;
  int                   stall_cnt = 0, pause_cnt = 0;
  bit                   fd_exp = 0, feeding = 0, aborted = 0;
  bit                   stall_arm = 0, pause_arm = 0, rst_arm = 0, want_first = 0;

  always #5 clk = ~clk;

  max_pool_stream #(.DATA_W(DW), .IN_DIM(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  task automatic check_dat(input string tag, input logic signed [DW-1:0] obs, input logic signed [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_pos(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs == expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef POOL_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // mode 0: ramp r*N+c, mode 1: all -5, otherwise random wide/narrow signed values
  task automatic build_frame(input int mode);
    logic [95:0]          rnd;
    logic signed [DW-1:0] m;
    int                   t;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        rnd = {$urandom, $urandom, $urandom};
        t   = int'($urandom_range(0, 40)) - 20;
        case (mode)
          0:       frame[r][c] = DW'(r * N + c);
          1:       frame[r][c] = DW'(-5);
          default: frame[r][c] = $urandom_range(0, 1) ? $signed(rnd[DW-1:0]) : DW'(t);
        endcase
      end
    end
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < P; j++) begin
        m = frame[2*i][2*j];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (frame[2*i+dr][2*j+dc] > m) m = frame[2*i+dr][2*j+dc];
        exp_q.push_back('{v: relu(m), r: i, c: j});
      end
    end
  endtask

  task automatic observe();
    exp_t e;
    check_bit("frame_done", frame_done, fd_exp);
    if (frame_done === 1'b1) n_fd++;
    fd_exp = 0;
    if (rst) begin
      check_bit("in_ready_rst", in_ready, 1'b0);
      exp_q.delete();
      in_r = 0;
      in_c = 0;
      aborted = 1;
      return;
    end
    if (!enable || (out_valid && !out_ready)) check_bit("in_ready_blocked", in_ready, 1'b0);
    if (stall_cnt > 0) begin
      check_bit("stall_valid", out_valid, 1'b1);
      if (exp_q.size() > 0) check_dat("stall_hold", out_data, exp_q[0].v);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_bit("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_dat("out_data", out_data, e.v);
        check_pos("out_row", out_row, PW'(e.r));
        check_pos("out_col", out_col, PW'(e.c));
        if (want_first) begin
          check_dat("first_after_rst", out_data, DW'(25));
          want_first = 0;
        end
        n_out++;
        if (e.r == P - 1 && e.c == P - 1) fd_exp = 1;
      end
    end
    if (feeding && in_valid && in_ready) begin
      accepted++;
      in_c++;
      if (in_c == N) begin
        in_c = 0;
        in_r = (in_r == N - 1) ? 0 : in_r + 1;
      end
    end
  endtask

  task automatic cycle();
    logic [95:0] junk;
    @(negedge clk);
    if (stall_arm && out_valid) begin
      stall_arm = 0;
      stall_cnt = 10;
    end
    if (pause_arm && feeding && in_r == 7 && in_c == 10) begin
      pause_arm = 0;
      pause_cnt = 5;
    end
    rst = rst_arm && feeding && in_r == 13 && in_c == 5;
    if (rst) rst_arm = 0;
    enable    = (pause_cnt == 0);
    in_valid  = feeding && ($urandom_range(0, 99) >= gap_pct);
    junk      = {$urandom, $urandom, $urandom};
    in_data   = feeding ? frame[in_r][in_c] : $signed(junk[DW-1:0]);
    out_ready = (stall_cnt == 0) && ($urandom_range(0, 99) >= stall_pct);
    #1;
    observe();
    if (stall_cnt > 0) stall_cnt--;
    if (pause_cnt > 0) pause_cnt--;
  endtask

  task automatic drive_frame(input int mode);
    int cyc = 0;
    build_frame(mode);
    accepted = 0;
    aborted  = 0;
    feeding  = 1;
    while (accepted < N * N && !aborted && cyc < MAX_CYC) begin
      cycle();
      cyc++;
    end
    feeding = 0;
    if (!aborted) check_int("feed_count", accepted, N * N);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() > 0 || fd_exp) && cyc < 2000) begin
      cycle();
      cyc++;
    end
    check_int("drain_left", exp_q.size(), 0);
    cycle();
  endtask

  task automatic run(input string name, input int mode, input int nframes, input int gp, input int sp,
                     input int want_out, input int want_fd);
    n_out     = 0;
    n_fd      = 0;
    gap_pct   = gp;
    stall_pct = sp;
    for (int k = 0; k < nframes; k++) drive_frame(mode);
    drain();
    check_int({name, "_outs"}, n_out, want_out);
    check_int({name, "_frame_done"}, n_fd, want_fd);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    repeat (2) @(negedge clk);
    #1;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_dat("rst_out_data", out_data, '0);
    check_pos("rst_out_row", out_row, '0);
    check_pos("rst_out_col", out_col, '0);
    check_bit("rst_frame_done", frame_done, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);

    run("ramp", 0, 1, 0, 0, P * P, 1);
    run("neg5", 1, 1, 0, 0, P * P, 1);

    stall_arm = 1;
    run("stall", 0, 1, 0, 0, P * P, 1);
    check_bit("stall_fired", stall_arm, 1'b0);

    pause_arm = 1;
    run("pause", 0, 1, 0, 0, P * P, 1);
    check_bit("pause_fired", pause_arm, 1'b0);

    rst_arm = 1;
    gap_pct = 0;
    stall_pct = 0;
    drive_frame(0);
    check_bit("rst_aborted", aborted, 1'b1);
    want_first = 1;
    run("after_rst", 0, 1, 0, 0, P * P, 1);
    check_bit("first_seen", want_first, 1'b0);

    run("b2b", 0, 2, 0, 0, 2 * P * P, 2);
    run("rand", 2, 2, 30, 30, 2 * P * P, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
